// File: rtl/spectro_serial_readout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spectro_serial_readout
// Brief    : Walks the spectrogram memory and shifts each {ch2,ch1} word out
//            MSB-first on two lanes with SL_time / SL_ch framing strobes.
// Revision : 1.0 - initial release
// ============================================================================
module spectro_serial_readout #(
    parameter int DATA_W = 7,
    parameter int N_TIME = 4,
    parameter int N_BIN  = 8,
    parameter int ADDR_W = 5
) (
    input  logic                  input_serial_readout_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2*DATA_W-1:0]   mem_rd_data,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [1:0]            serial_out,
    output logic                  SL_time,
    output logic                  SL_ch,
    output logic                  serial_readout,
    output logic                  sending_data,
    output logic                  readout_done
);

    localparam int SLOT_W = (N_TIME > 1) ? $clog2(N_TIME) : 1;
    localparam int BIN_W  = (N_BIN  > 1) ? $clog2(N_BIN)  : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [SLOT_W-1:0] c_SLOT_LAST = SLOT_W'(N_TIME - 1);
    localparam logic [BIN_W-1:0]  c_BIN_LAST  = BIN_W'(N_BIN - 1);
    localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LOAD     = 3'd2,
        S_SHIFT    = 3'd3,
        S_DONE     = 3'd4,
        S_WAIT_LOW = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [SLOT_W-1:0]   r_slot;
    logic [BIN_W-1:0]    r_bin;
    logic [BIT_W-1:0]    r_bitcnt;
    logic [DATA_W-1:0]   r_sh1;
    logic [DATA_W-1:0]   r_sh2;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_last_bit;
    logic                w_last_word;

    assign w_last_bit  = (r_bitcnt == c_BIT_LAST);
    assign w_last_word = (r_bin == c_BIN_LAST) && (r_slot == c_SLOT_LAST);
    assign w_addr      = ADDR_W'(r_slot) * ADDR_W'(N_BIN) + ADDR_W'(r_bin);

    always_ff @(posedge input_serial_readout_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Counters and shift registers; counters saturate at their last value
    // and are re-armed by IDLE (slot/bin) or LOAD (bitcnt).
    always_ff @(posedge input_serial_readout_clk or posedge reset) begin
        if (reset) begin
            r_slot   <= '0;
            r_bin    <= '0;
            r_bitcnt <= '0;
            r_sh1    <= '0;
            r_sh2    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_slot <= '0;
                        r_bin  <= '0;
                    end
                end
                S_LOAD: begin
                    r_sh1    <= mem_rd_data[DATA_W-1:0];
                    r_sh2    <= mem_rd_data[2*DATA_W-1:DATA_W];
                    r_bitcnt <= '0;
                end
                S_SHIFT: begin
                    r_sh1 <= {r_sh1[DATA_W-2:0], 1'b0};
                    r_sh2 <= {r_sh2[DATA_W-2:0], 1'b0};
                    if (w_last_bit) begin
                        if (r_bin != c_BIN_LAST) begin
                            r_bin <= r_bin + 1'b1;
                        end else begin
                            r_bin <= '0;
                            if (r_slot != c_SLOT_LAST) begin
                                r_slot <= r_slot + 1'b1;
                            end
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next         = r_state;
        mem_rd_en      = 1'b0;
        mem_addr       = '0;
        serial_out     = 2'b00;
        SL_time        = 1'b0;
        SL_ch          = 1'b0;
        serial_readout = 1'b0;
        sending_data   = 1'b0;
        readout_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd_en      = 1'b1;
                mem_addr       = w_addr;
                serial_readout = 1'b1;
                w_next         = S_LOAD;
            end
            S_LOAD: begin
                mem_addr       = w_addr;
                serial_readout = 1'b1;
                w_next         = S_SHIFT;
            end
            S_SHIFT: begin
                mem_addr       = w_addr;
                serial_readout = 1'b1;
                sending_data   = 1'b1;
                serial_out     = {r_sh2[DATA_W-1], r_sh1[DATA_W-1]};
                SL_ch          = (r_bitcnt == '0);
                SL_time        = (r_bitcnt == '0) && (r_bin == '0);
                if (w_last_bit) begin
                    w_next = w_last_word ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                serial_readout = 1'b1;
                readout_done   = 1'b1;
                w_next         = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!start) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spectro_serial_readout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spectro_serial_readout
// Brief    : Self-checking bench: vector table, hand sequences and random
//            frames checked against a per-cycle frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spectro_serial_readout;

    localparam int DW    = 7;
    localparam int NT    = 4;
    localparam int NB    = 8;
    localparam int AW    = 5;
    localparam int NW    = NT * NB;
    localparam int WP    = DW + 2;
    localparam int FRAME = NW * WP;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2*DW-1:0]   rd_data = '0;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_addr;
    logic [1:0]        serial_out;
    logic              SL_time;
    logic              SL_ch;
    logic              serial_readout;
    logic              sending_data;
    logic              readout_done;

    logic [2*DW-1:0]   mem [NW];
    logic [12:0]       exp_v [FRAME+1];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        start;
        logic [12:0] exp;
    } vec_t;

    spectro_serial_readout #(
        .DATA_W(DW), .N_TIME(NT), .N_BIN(NB), .ADDR_W(AW)
    ) dut (
        .input_serial_readout_clk(clk),
        .reset(reset),
        .start(start),
        .mem_rd_data(rd_data),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .serial_out(serial_out),
        .SL_time(SL_time),
        .SL_ch(SL_ch),
        .serial_readout(serial_readout),
        .sending_data(sending_data),
        .readout_done(readout_done)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd_en) rd_data <= mem[mem_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [12:0] pack(input logic rd, input logic [AW-1:0] ad,
                                         input logic [1:0] so, input logic slt,
                                         input logic slc, input logic srd,
                                         input logic snd, input logic dn);
        return {rd, ad, so, slt, slc, srd, snd, dn};
    endfunction

    function automatic logic [12:0] act();
        return {mem_rd_en, mem_addr, serial_out, SL_time, SL_ch,
                serial_readout, sending_data, readout_done};
    endfunction

    task automatic chk(input string nm, input logic [12:0] a, input logic [12:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // Expected output per cycle, cycle 0 = first FETCH: each word is FETCH,
    // LOAD then DW bits; DONE follows the last word.
    function automatic void build_model();
        for (int w = 0; w < NW; w++) begin
            int base = w * WP;
            exp_v[base]     = pack(1'b1, AW'(w), 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            exp_v[base + 1] = pack(1'b0, AW'(w), 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            for (int b = 0; b < DW; b++) begin
                logic [1:0] so;
                so = {mem[w][2*DW-1-b], mem[w][DW-1-b]};
                exp_v[base + 2 + b] = pack(1'b0, AW'(w), so,
                                           (b == 0) && (w % NB == 0), (b == 0),
                                           1'b1, 1'b1, 1'b0);
            end
        end
        exp_v[FRAME] = pack(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endfunction

    // Call at a negedge with the DUT in IDLE; raises start and checks the frame.
    task automatic run_frame(input string nm, input int drop_cyc, input int abort_cyc);
        logic [DW-1:0] g1 [NW];
        logic [DW-1:0] g2 [NW];
        logic [12:0]   m;
        int wi = -1, slc = 0, slt = 0, slt_bad = 0, done_at = -1, done_cnt = 0;
        build_model();
        start = 1'b1;
        for (int cyc = 0; cyc <= FRAME; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            m = 13'h1fff;
            if (exp_v[cyc][0]) m[11:7] = 5'b0;
            chk($sformatf("%s cyc%0d", nm, cyc), act() & m, exp_v[cyc] & m);
            if (sending_data) begin
                if (SL_ch) begin
                    wi++;
                    slc++;
                    if (SL_time) begin
                        slt++;
                        if (wi % NB != 0) slt_bad++;
                    end
                end
                if (wi >= 0 && wi < NW) begin
                    g1[wi] = {g1[wi][DW-2:0], serial_out[0]};
                    g2[wi] = {g2[wi][DW-2:0], serial_out[1]};
                end
            end
            if (readout_done) begin
                done_cnt++;
                done_at = cyc;
            end
            if (cyc == drop_cyc) start = 1'b0;
            if (cyc == abort_cyc) begin
                reset = 1'b1;
                #1;
                chk({nm, " async reset"}, act(), 13'h0);
                start = 1'b0;
                return;
            end
        end
        chk_int({nm, " done cycle"}, done_at, FRAME);
        chk_int({nm, " done count"}, done_cnt, 1);
        chk_int({nm, " SL_ch count"}, slc, NW);
        chk_int({nm, " SL_time count"}, slt, NT);
        chk_int({nm, " SL_time misplaced"}, slt_bad, 0);
        for (int w = 0; w < NW; w++) begin
            chk($sformatf("%s word%0d", nm, w), 13'({g2[w], g1[w]}), 13'(mem[w]));
        end
    endtask

    task automatic idle_cycles(input string nm, input int n);
        int nz = 0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (act() !== 13'h0) nz++;
        end
        chk_int({nm, " nonzero output cycles"}, nz, 0);
    endtask

    initial begin
        vec_t tbl [11];
        reset = 1'b1;
        start = 1'b0;
        for (int a = 0; a < NW; a++) mem[a] = '0;

        // Reset held: start toggling must not produce any output
        repeat (6) begin
            @(negedge clk);
            start = ~start;
            @(posedge clk);
            #1;
            chk("reset_hold", act(), 13'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        idle_cycles("idle_after_reset", 2);

        // Single word {7'h55, 7'h2A}: ch1 lane 0101010, ch2 lane 1010101
        mem[0] = {7'h55, 7'h2A};
        mem[1] = 14'h0;
        tbl[0]  = '{1'b1, pack(1'b1, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[1]  = '{1'b1, pack(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[2]  = '{1'b1, pack(1'b0, 5'd0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0)};
        tbl[3]  = '{1'b0, pack(1'b0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
        tbl[4]  = '{1'b0, pack(1'b0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
        tbl[5]  = '{1'b1, pack(1'b0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
        tbl[6]  = '{1'b1, pack(1'b0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
        tbl[7]  = '{1'b1, pack(1'b0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
        tbl[8]  = '{1'b1, pack(1'b0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
        tbl[9]  = '{1'b1, pack(1'b1, 5'd1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[10] = '{1'b1, pack(1'b0, 5'd1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = tbl[i].start;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), act(), tbl[i].exp);
        end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Full frame {a, ~a}, then start held high must not re-arm
        for (int a = 0; a < NW; a++) begin
            logic [DW-1:0] av;
            av = DW'(a);
            mem[a] = {av, ~av};
        end
        run_frame("frame1", -1, -1);
        idle_cycles("start_held", 20);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        run_frame("frame2", -1, -1);

        // Reset during word 5 bit 3, then idle until start, then restart
        start = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        run_frame("abort", -1, 5 * WP + 2 + 3);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles("after_abort", 5);
        run_frame("restart", -1, -1);

        // start dropped during word 10 is ignored
        start = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        run_frame("drop10", 10 * WP + 4, -1);

        // Random memory contents with a random start drop point
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < NW; a++) mem[a] = (2*DW)'($urandom);
            start = 1'b0;
            repeat (2) begin @(posedge clk); @(negedge clk); end
            run_frame($sformatf("rand%0d", r), int'($urandom_range(0, FRAME - 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spectro_serial_readout.md
Name: spectro_serial_readout

Overview:
- Downstream readout stage of the spectrogram extractor.
- After memorization completes, it walks the spectrogram memory (N_TIME time slots × N_BIN bins; each word is {ch2[6:0], ch1[6:0]}).
- Each word is shifted out MSB-first on two parallel lanes: lane 0 carries ch1, lane 1 carries ch2.
- Framing strobes SL_time and SL_ch, plus readout-status flags, are driven to the pads.

Parameters:
DATA_W, 7, bits per channel sample
N_TIME, 4, time slots stored in memory
N_BIN, 8, frequency bins per time slot
ADDR_W, 5, memory address width; N_TIME*N_BIN <= 2**ADDR_W is required

Ports:
input_serial_readout_clk  in  1  readout clock; every register is on its rising edge
reset  in  1  asynchronous, active-high; clears every register immediately
start  in  1  memorization-completed level from the memory stage; only sampled in IDLE
mem_rd_data  in  2*DATA_W  synchronous memory read data {ch2,ch1}; valid 1 cycle after mem_rd_en
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  read address = slot*N_BIN + bin
serial_out  out  2  [0]=ch1 bit, [1]=ch2 bit, MSB first
SL_time  out  1  high during first bit of bin 0 of each slot
SL_ch  out  1  high during first bit of every bin word
serial_readout  out  1  high from FETCH of word 0 until DONE (inclusive)
sending_data  out  1  high exactly while valid bits are on serial_out
readout_done  out  1  one-cycle pulse after last bit of last word

Behaviour:
- Reset (async, any state): state=IDLE; slot=bin=bitcnt=0; shift registers=0; all outputs=0.
- States: IDLE, FETCH, LOAD, SHIFT, DONE, WAIT_LOW.
- IDLE:
  - Outputs 0.
  - If start=1 at a clock edge -> FETCH next cycle; slot=bin=0.
- FETCH (1 cycle):
  - mem_rd_en=1, mem_addr=slot*N_BIN+bin; mem_addr holds this value through LOAD and SHIFT.
  - mem_rd_en is 0 in every other state. -> LOAD.
- LOAD (1 cycle):
  - At the end-of-cycle edge: sh1 <= mem_rd_data[DATA_W-1:0], sh2 <= mem_rd_data[2*DATA_W-1:DATA_W], bitcnt <= 0. -> SHIFT.
- SHIFT (DATA_W cycles):
  - serial_out = {sh2[MSB], sh1[MSB]}; sending_data=1.
  - Each edge left-shifts sh1/sh2 (zero-fill) and increments bitcnt.
  - SL_ch=1 only while bitcnt=0; SL_time=1 only while bitcnt=0 and bin=0.
  - After the bitcnt=DATA_W-1 cycle:
    - bin<N_BIN-1: bin+1 -> FETCH.
    - else bin=0; slot<N_TIME-1: slot+1 -> FETCH.
    - else -> DONE.
- Outside SHIFT: serial_out=0, sending_data=0, SL_ch=0, SL_time=0.
- Word period is DATA_W+2 = 9 cycles, with a 2-cycle gap (FETCH, LOAD) between words.
- Full readout from first FETCH to DONE = N_TIME*N_BIN*(DATA_W+2) = 288 cycles at default parameters.
- DONE (1 cycle): readout_done=1, serial_readout=1. -> WAIT_LOW.
- WAIT_LOW:
  - All outputs 0; stays until start=0, then -> IDLE.
  - start held high therefore yields exactly one readout; re-arming requires a low then a high.
- start changes during FETCH/LOAD/SHIFT are ignored; the readout always completes unless reset.
- Reset asserted mid-SHIFT: outputs drop to 0 asynchronously. After release, no output until a new start is sampled in IDLE.
- Counters never wrap past N_TIME-1 / N_BIN-1 / DATA_W-1.
- Outputs are decoded only from registered state and counters: no combinational path from the inputs.

Test Plan:
- Reset check: hold reset, toggle start -> every output stays 0. Release, start=1 -> mem_rd_en=1, mem_addr=0 one cycle later.
- Single word value: memory word 0 = {7'h55, 7'h2A}.
  - Lane 0 (ch1) = 0,1,0,1,0,1,0; lane 1 (ch2) = 1,0,1,0,1,0,1.
  - sending_data high for exactly 7 cycles; SL_ch and SL_time high on the first bit only.
- Full frame: memory[a] = {a, ~a} for a=0..31.
  - Bench reassembles 32 words in address order 0..31.
  - SL_ch pulses 32 times; SL_time pulses 4 times, at words 0, 8, 16, 24.
  - readout_done pulses once, 288 cycles after the first FETCH.
- Start held high after done: no second readout. Drop start 1 cycle, raise it -> second identical readout.
- Reset mid-readout during word 5, bit 3: outputs 0 immediately. After release with start=0 -> stays IDLE. start=1 -> restarts at mem_addr=0.
- start deasserted during SHIFT of word 10 -> readout continues to all 32 words; readout_done asserts normally.
